// File: rtl/eth_axis_tx_arbiter_core.sv
// Frame-atomic round-robin merge of CHANNELS AXI-Stream TX sources into one
// MAC-facing stream. A frame that runs past MAX_FRAME_LEN beats is cut short
// with tlast+tuser, and its tail is swallowed. Per-channel frame counters and
// a truncation counter are provided for status.

// Per-channel slice: ready gating plus that channel's forwarded-frame counter.
module eth_axis_tx_arbiter_chan #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel_i,
  input  logic                 ready_en_i,
  input  logic                 frame_done_i,
  output logic                 tready_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign tready_o    = sel_i & ready_en_i;
  assign frame_cnt_o = cnt_q;

  // Count a frame when its last beat (real or forced) enters the output register; wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (sel_i && frame_done_i) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

module eth_axis_tx_arbiter_core #(
  parameter int CHANNELS      = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 16,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic [CH_W-1:0]                m_axis_tid,
  output logic [CHANNELS*CNT_WIDTH-1:0]  stat_frame_count,
  output logic [CNT_WIDTH-1:0]           stat_trunc_count,
  output logic                           busy
);
  localparam int BC_W = $clog2(MAX_FRAME_LEN + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DROP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CH_W-1:0]       rr_q, rr_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [BC_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  m_tuser_q, m_tuser_d;
  logic [CH_W-1:0]       m_tid_q, m_tid_d;
  logic [CNT_WIDTH-1:0]  trunc_q, trunc_d;

  logic [DATA_WIDTH-1:0] s_data_a [CHANNELS];
  logic                  g_valid, g_last, g_user;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  load_en, accept, trunc_hit, frame_done, ready_en;
  logic                  arb_hit;
  logic [CH_W-1:0]       arb_idx, cand;

  // Per-channel slices: data unpacking, ready gating, frame counters.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign s_data_a[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    eth_axis_tx_arbiter_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
      .clk          (clk),
      .rst          (rst),
      .sel_i        (grant_q == CH_W'(i)),
      .ready_en_i   (ready_en),
      .frame_done_i (frame_done),
      .tready_o     (s_axis_tready[i]),
      .frame_cnt_o  (stat_frame_count[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  assign g_valid = s_axis_tvalid[grant_q];
  assign g_last  = s_axis_tlast[grant_q];
  assign g_user  = s_axis_tuser[grant_q];
  assign g_data  = s_data_a[grant_q];

  // The output register may take a new beat when empty or being drained.
  assign load_en    = !m_tvalid_q || m_axis_tready;
  assign ready_en   = (state_q == S_ACTIVE) ? load_en : (state_q == S_DROP);
  assign accept     = (state_q == S_ACTIVE) && load_en && g_valid;
  assign trunc_hit  = accept && !g_last &&
                      ((beat_cnt_q + BC_W'(1)) == BC_W'(MAX_FRAME_LEN));
  assign frame_done = accept && (g_last || trunc_hit);

  // Round-robin search: first requesting channel after rr_q, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_q;
    cand    = rr_q;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = CH_W'((int'(rr_q) + i) % CHANNELS);
      if (!arb_hit && s_axis_tvalid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Frame FSM, beat counter, output register and truncation counter next-state.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    m_tid_d    = m_tid_q;
    trunc_d    = trunc_q;

    if (load_en) m_tvalid_d = accept;
    if (accept) begin
      m_tdata_d  = g_data;
      m_tid_d    = grant_q;
      m_tlast_d  = g_last || trunc_hit;
      m_tuser_d  = (g_user && g_last) || trunc_hit;
      beat_cnt_d = beat_cnt_q + BC_W'(1);
    end
    if (trunc_hit) trunc_d = trunc_q + CNT_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          grant_d    = arb_idx;
          beat_cnt_d = '0;
          state_d    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (accept && g_last) begin
          rr_d    = grant_q;
          state_d = S_IDLE;
        end else if (trunc_hit) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (g_valid && g_last) begin
          rr_d    = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight frame and the output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= CH_W'(CHANNELS - 1);
      grant_q    <= '0;
      beat_cnt_q <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      m_tid_q    <= '0;
      trunc_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      m_tid_q    <= m_tid_d;
      trunc_q    <= trunc_d;
    end
  end

  assign m_axis_tdata     = m_tdata_q;
  assign m_axis_tvalid    = m_tvalid_q;
  assign m_axis_tlast     = m_tlast_q;
  assign m_axis_tuser     = m_tuser_q;
  assign m_axis_tid       = m_tid_q;
  assign stat_trunc_count = trunc_q;
  assign busy             = (state_q != S_IDLE) || m_tvalid_q;
endmodule

// File: tb/tb_eth_axis_tx_arbiter_core.sv
// Directed bench for eth_axis_tx_arbiter_core: cycle tables for single-frame
// latency and backpressure, plus hand-written sequences for truncation,
// counter wrap, mid-frame reset and round-robin fairness.
module tb_eth_axis_tx_arbiter_core;
  localparam int NCH = 4, DW = 8, MFL = 16, CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tready, m_tlast, m_tuser;
  logic [1:0]        m_tid;
  logic [NCH*CW-1:0] stat_fc;
  logic [CW-1:0]     stat_tr;
  logic              busy;

  always #5 clk = ~clk;

  eth_axis_tx_arbiter_core #(
    .CHANNELS(NCH), .DATA_WIDTH(DW), .MAX_FRAME_LEN(MFL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tid(m_tid),
    .stat_frame_count(stat_fc), .stat_trunc_count(stat_tr), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Output beat monitor for the hand-written sequences.
  typedef struct { logic [7:0] d; logic l; logic u; logic [1:0] id; } beat_t;
  beat_t mq[$];
  logic  mon_en = 1'b0;
  always @(negedge clk)
    if (mon_en && m_tvalid && m_tready) mq.push_back('{m_tdata, m_tlast, m_tuser, m_tid});

  // Cycle vectors: inputs applied after a rising edge, outputs checked at the falling edge.
  typedef struct {
    logic [3:0] vld; logic [3:0] lst; logic [7:0] dat; logic mrdy;
    logic [3:0] e_srdy; logic e_mvld; logic [7:0] e_mdat; logic e_mlst; logic [1:0] e_mtid; logic e_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] vld, input logic [3:0] lst, input logic [7:0] dat,
                     input logic mrdy, input logic [3:0] e_srdy, input logic e_mvld,
                     input logic [7:0] e_mdat, input logic e_mlst, input logic [1:0] e_mtid,
                     input logic e_busy);
    vec_t v;
    v = '{vld, lst, dat, mrdy, e_srdy, e_mvld, e_mdat, e_mlst, e_mtid, e_busy};
    tbl.push_back(v);
  endtask

  // Drive one frame on channel ch, honouring tready with a bounded wait per beat.
  task automatic send_frame(input int ch, input int n, input logic usr, input logic [7:0] base);
    int w;
    for (int b = 1; b <= n; b++) begin
      s_tvalid[ch]          = 1'b1;
      s_tdata[ch*DW +: DW]  = base + 8'(b);
      s_tlast[ch]           = (b == n);
      s_tuser[ch]           = usr && (b == n);
      w = 0;
      @(negedge clk);
      while (!s_tready[ch] && w < 50) begin
        w++;
        @(negedge clk);
      end
      if (w >= 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL hs_timeout ch%0d beat %0d: tready never seen, required within 50 cycles", ch, b);
      end
      @(posedge clk); #1;
    end
    s_tvalid[ch] = 1'b0;
    s_tlast[ch]  = 1'b0;
    s_tuser[ch]  = 1'b0;
  endtask

  initial begin
    logic prev_vld;
    int   exp_tid, nbeats;

    rst = 1'b1; s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mvld", m_tvalid, 0);
    chk("rst_mdat", m_tdata, 0);
    chk("rst_mtid", m_tid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_srdy", s_tready, 0);
    chk("rst_fc", stat_fc, 0);
    chk("rst_tr", stat_tr, 0);
    @(posedge clk); #1;

    // 3-beat frame on ch2: A1 out two cycles after tvalid rises.
    add(4'b0100, 4'b0000, 8'hA1, 1, 4'b0000, 0, 8'h00, 0, 0, 0);
    add(4'b0100, 4'b0000, 8'hA1, 1, 4'b0100, 0, 8'h00, 0, 0, 1);
    add(4'b0100, 4'b0000, 8'hA2, 1, 4'b0100, 1, 8'hA1, 0, 2, 1);
    add(4'b0100, 4'b0100, 8'hA3, 1, 4'b0100, 1, 8'hA2, 0, 2, 1);
    add(4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 1, 8'hA3, 1, 2, 1);
    add(4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 0);
    // 4-beat frame on ch1 with the sink stalled for 5 cycles while beat 2 is presented.
    add(4'b0010, 4'b0000, 8'hB1, 1, 4'b0000, 0, 8'h00, 0, 0, 0);
    add(4'b0010, 4'b0000, 8'hB1, 1, 4'b0010, 0, 8'h00, 0, 0, 1);
    add(4'b0010, 4'b0000, 8'hB2, 1, 4'b0010, 1, 8'hB1, 0, 1, 1);
    for (int k = 0; k < 5; k++)
      add(4'b0010, 4'b0000, 8'hB3, 0, 4'b0000, 1, 8'hB2, 0, 1, 1);
    add(4'b0010, 4'b0000, 8'hB3, 1, 4'b0010, 1, 8'hB2, 0, 1, 1);
    add(4'b0010, 4'b0010, 8'hB4, 1, 4'b0010, 1, 8'hB3, 0, 1, 1);
    add(4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 1, 8'hB4, 1, 1, 1);
    add(4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 0);

    foreach (tbl[k]) begin
      s_tvalid = tbl[k].vld;
      s_tlast  = tbl[k].lst;
      s_tuser  = '0;
      s_tdata  = {NCH{tbl[k].dat}};
      m_tready = tbl[k].mrdy;
      @(negedge clk);
      chk($sformatf("vec%0d_srdy", k), s_tready, tbl[k].e_srdy);
      chk($sformatf("vec%0d_mvld", k), m_tvalid, tbl[k].e_mvld);
      chk($sformatf("vec%0d_busy", k), busy, tbl[k].e_busy);
      if (tbl[k].e_mvld) begin
        chk($sformatf("vec%0d_mdat", k), m_tdata, tbl[k].e_mdat);
        chk($sformatf("vec%0d_mlst", k), m_tlast, tbl[k].e_mlst);
        chk($sformatf("vec%0d_mtid", k), m_tid, tbl[k].e_mtid);
        chk($sformatf("vec%0d_musr", k), m_tuser, 0);
      end
      @(posedge clk); #1;
    end
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    chk("tbl_fc2", stat_fc[2*CW +: CW], 1);
    chk("tbl_fc1", stat_fc[1*CW +: CW], 1);

    // Oversize frame on ch1: 16 beats forwarded, last one forced tlast+tuser, tail dropped.
    mq.delete(); mon_en = 1'b1;
    send_frame(1, 20, 1'b0, 8'h00);
    repeat (3) @(posedge clk); #1;
    chk("trunc_nbeats", mq.size(), 16);
    foreach (mq[i]) begin
      chk($sformatf("trunc_b%0d_dat", i), mq[i].d, i + 1);
      chk($sformatf("trunc_b%0d_lst", i), mq[i].l, (i == 15));
      chk($sformatf("trunc_b%0d_usr", i), mq[i].u, (i == 15));
      chk($sformatf("trunc_b%0d_tid", i), mq[i].id, 1);
    end
    chk("trunc_cnt", stat_tr, 1);
    chk("trunc_fc1", stat_fc[1*CW +: CW], 2);
    chk("trunc_busy", busy, 0);

    // Exactly MAX_FRAME_LEN beats ending in tlast is a good frame.
    mq.delete();
    send_frame(1, 16, 1'b0, 8'h40);
    repeat (3) @(posedge clk); #1;
    chk("full_nbeats", mq.size(), 16);
    if (mq.size() == 16) begin
      chk("full_last_lst", mq[15].l, 1);
      chk("full_last_usr", mq[15].u, 0);
      chk("full_last_dat", mq[15].d, 8'h50);
      chk("full_b14_lst", mq[14].l, 0);
    end
    chk("full_trunc_cnt", stat_tr, 1);
    chk("full_fc1", stat_fc[1*CW +: CW], 3);

    // 17 frames on ch0 wrap its 4-bit counter to 1; source error on the last one.
    mq.delete();
    for (int f = 0; f < 17; f++) send_frame(0, 2, (f == 16), 8'(f * 2));
    repeat (3) @(posedge clk); #1;
    chk("wrap_fc0", stat_fc[0*CW +: CW], 1);
    chk("wrap_nbeats", mq.size(), 34);
    if (mq.size() == 34) begin
      chk("wrap_last_usr", mq[33].u, 1);
      chk("wrap_last_lst", mq[33].l, 1);
      chk("wrap_prev_usr", mq[31].u, 0);
      chk("wrap_prev_lst", mq[31].l, 1);
    end
    chk("wrap_trunc_cnt", stat_tr, 1);
    mon_en = 1'b0;

    // Reset one cycle mid-frame on ch3.
    s_tvalid[3] = 1'b1; s_tdata[3*DW +: DW] = 8'hD0; s_tlast[3] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    chk("midrst_mtid_before", m_tid, 3);
    @(posedge clk); #1;
    rst = 1'b1; s_tvalid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_mvld", m_tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fc", stat_fc, 0);
    chk("midrst_tr", stat_tr, 0);
    chk("midrst_srdy", s_tready, 0);
    @(posedge clk); #1;

    // All channels offer back-to-back 1-beat frames: 0,1,2,3,... with one bubble between.
    for (int c = 0; c < NCH; c++) s_tdata[c*DW +: DW] = 8'hC0 | 8'(c);
    s_tlast = '1; s_tvalid = '1;
    prev_vld = 1'b0; exp_tid = 0; nbeats = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_tvalid) begin
        chk($sformatf("rr_beat%0d_tid", nbeats), m_tid, exp_tid);
        chk($sformatf("rr_beat%0d_dat", nbeats), m_tdata, 8'hC0 | 8'(exp_tid));
        chk($sformatf("rr_beat%0d_bubble", nbeats), prev_vld, 0);
        exp_tid = (exp_tid + 1) % NCH;
        nbeats++;
      end
      prev_vld = m_tvalid;
    end
    chk("rr_nbeats", nbeats, 9);
    chk("rr_fc0", stat_fc[0*CW +: CW], 3);
    chk("rr_fc1", stat_fc[1*CW +: CW], 2);
    chk("rr_fc3", stat_fc[3*CW +: CW], 2);
    @(posedge clk); #1;
    rst = 1'b1; s_tvalid = '0; s_tlast = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
